// File: rtl/stream_mux_arb.sv
// stream_mux_arb: M-channel stream multiplexer with external-select or round-robin
// arbitration, feeding a single registered valid/ready output stage.
module stream_mux_arb #(
    parameter int N     = 32,
    parameter int M     = 4,
    parameter int SEL_W = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [M-1:0]     InValid,
    input  logic [M*N-1:0]   InData,
    output logic [M-1:0]     InReady,
    input  logic             Mode,
    input  logic [SEL_W-1:0] Sel,
    output logic             OutValid,
    output logic [N-1:0]     OutData,
    output logic [SEL_W-1:0] OutChan,
    input  logic             OutReady
);

    logic             r_out_valid;
    logic [N-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic             w_grant_vld;
    logic [SEL_W-1:0] w_grant_idx;
    logic [SEL_W-1:0] w_next_ptr;
    logic [N-1:0]     w_grant_data;
    logic             w_xfer;
    logic [M-1:0]     w_valid_sh;
    logic [M*N-1:0]   w_data_sh;
    logic             w_hi_found;
    logic             w_lo_found;
    logic [SEL_W-1:0] w_hi_idx;
    logic [SEL_W-1:0] w_lo_idx;

    // Round-robin search: lowest valid channel at/above the pointer, else lowest overall (wrap).
    always_comb begin
        w_load_en   = !r_out_valid || OutReady;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_hi_found  = 1'b0;
        w_lo_found  = 1'b0;
        w_hi_idx    = '0;
        w_lo_idx    = '0;
        w_valid_sh  = '0;
        for (int unsigned i = 0; i < M; i++) begin
            w_valid_sh = InValid >> i;
            if (w_valid_sh[0]) begin
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = SEL_W'(i);
                end
                if (!w_hi_found && (SEL_W'(i) >= r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SEL_W'(i);
                end
            end
        end
        if (Mode) begin
            if (w_hi_found) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_hi_idx;
            end else if (w_lo_found) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_lo_idx;
            end
        end else if (int'(Sel) < M) begin
            w_valid_sh  = InValid >> Sel;
            w_grant_vld = w_valid_sh[0];
            w_grant_idx = Sel;
        end
    end

    always_comb begin
        w_data_sh    = InData >> (int'(w_grant_idx) * N);
        w_grant_data = w_data_sh[N-1:0];
    end

    always_comb begin
        InReady = '0;
        if (w_grant_vld && w_load_en && !Rst) begin
            InReady = M'(1) << w_grant_idx;
        end
    end

    assign w_xfer     = |(InValid & InReady);
    assign w_next_ptr = (w_grant_idx == SEL_W'(M - 1)) ? '0 : w_grant_idx + SEL_W'(1);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_chan  <= w_grant_idx;
            if (Mode) begin
                r_rr_ptr <= w_next_ptr;
            end
        end else if (OutReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign OutValid = r_out_valid;
    assign OutData  = r_out_data;
    assign OutChan  = r_out_chan;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_stream_mux_arb;

    localparam int N  = 32;
    localparam int M  = 4;
    localparam int SW = 2;
    localparam int N3 = 8;
    localparam int M3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [M-1:0]    in_valid;
    logic [M*N-1:0]  in_data;
    logic [M-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic            out_valid;
    logic [N-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_ready;

    logic            rst3;
    logic [M3-1:0]   in_valid3;
    logic [M3*N3-1:0] in_data3;
    logic [M3-1:0]   in_ready3;
    logic            mode3;
    logic [SW-1:0]   sel3;
    logic            out_valid3;
    logic [N3-1:0]   out_data3;
    logic [SW-1:0]   out_chan3;
    logic            out_ready3;

    stream_mux_arb #(.N(N), .M(M), .SEL_W(SW)) dut (
        .Clk(clk), .Rst(rst), .InValid(in_valid), .InData(in_data), .InReady(in_ready),
        .Mode(mode), .Sel(sel), .OutValid(out_valid), .OutData(out_data),
        .OutChan(out_chan), .OutReady(out_ready)
    );

    stream_mux_arb #(.N(N3), .M(M3), .SEL_W(SW)) dut3 (
        .Clk(clk), .Rst(rst3), .InValid(in_valid3), .InData(in_data3), .InReady(in_ready3),
        .Mode(mode3), .Sel(sel3), .OutValid(out_valid3), .OutData(out_data3),
        .OutChan(out_chan3), .OutReady(out_ready3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the word held at the output and the round-robin pointer.
    logic         m_valid;
    logic [N-1:0] m_data;
    int           m_chan;
    int           m_ptr;

    function automatic logic [M-1:0] exp_ready();
        int c;
        if (rst) return '0;
        if (m_valid && !out_ready) return '0;
        if (!mode) begin
            if (int'(sel) < M && in_valid[sel]) return M'(1) << sel;
            return '0;
        end
        for (int k = 0; k < M; k++) begin
            c = (m_ptr + k) % M;
            if (in_valid[c]) return M'(1) << c;
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = 0;
    endtask

    task automatic model_tick();
        logic [M-1:0] r;
        int g;
        r = exp_ready();
        g = -1;
        for (int i = 0; i < M; i++) if (r[i]) g = i;
        @(posedge clk);
        if (g >= 0) begin
            m_data  = in_data[g*N +: N];
            m_chan  = g;
            m_valid = 1'b1;
            if (mode) m_ptr = (g + 1) % M;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < M; i++) in_data[i*N +: N] = $urandom();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [M-1:0] exp;
        rst = 1'b1; in_valid = '1; mode = 1'b1; out_ready = 1'b1; rand_data();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h chan=%0d, want 0/0/0", out_valid, out_data, out_chan);
        end
        n_checks++;
        if (in_ready !== '0) begin
            n_fail++; $display("FAIL reset_ready: in_ready=%b want 0000", in_ready);
        end
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0; mode = 1'b0; sel = '0; in_valid = 4'b0001; out_ready = 1'b0;
        in_data[N-1:0] = 32'hDEADBEEF;
        model_tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL reset_preload: valid=%b data=%h want 1/deadbeef", out_valid, out_data);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || in_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b data=%h chan=%0d rdy=%b want all 0", out_valid, out_data, out_chan, in_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        #1;
        exp = exp_ready();
        n_checks++;
        if (in_ready !== 4'b0001 || in_ready !== exp) begin
            n_fail++; $display("FAIL reset_first_rr: in_ready=%b want 0001", in_ready);
        end
        model_tick();
        n_checks++;
        if (out_chan !== 2'd0 || out_data !== m_data) begin
            n_fail++; $display("FAIL reset_first_chan: chan=%0d data=%h want 0/%h", out_chan, out_data, m_data);
        end
    endtask

    task automatic test_select();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < M; i++) in_data[i*N +: N] = 32'h10 + i;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL select_ready: in_ready=%b want 0100", in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            model_tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h12 || out_chan !== 2'd2) begin
                n_fail++;
                $display("FAIL select_stream[%0d]: valid=%b data=%h chan=%0d want 1/12/2", c, out_valid, out_data, out_chan);
            end
        end
    endtask

    task automatic test_fairness();
        int cnt [M];
        int p0;
        logic [M-1:0] exp;
        for (int i = 0; i < M; i++) cnt[i] = 0;
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        p0 = m_ptr;
        for (int c = 0; c < 2*M; c++) begin
            rand_data();
            #1;
            exp = exp_ready();
            n_checks++;
            if (in_ready !== exp) begin
                n_fail++; $display("FAIL fair_ready[%0d]: in_ready=%b want %b", c, in_ready, exp);
            end
            for (int i = 0; i < M; i++) if (in_ready[i]) cnt[i]++;
            model_tick();
            n_checks++;
            if (out_chan !== SW'((p0 + c) % M) || out_data !== m_data || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fair_grant[%0d]: chan=%0d data=%h want %0d/%h", c, out_chan, out_data, (p0 + c) % M, m_data);
            end
        end
        for (int i = 0; i < M; i++) begin
            n_checks++;
            if (cnt[i] !== 2) begin
                n_fail++; $display("FAIL fair_count[%0d]: grants=%0d want 2", i, cnt[i]);
            end
        end
    endtask

    task automatic test_sparse();
        int exp_g [4] = '{3, 1, 3, 1};
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0010; rand_data();
        #1;
        model_tick();
        n_checks++;
        if (out_chan !== 2'd1) begin
            n_fail++; $display("FAIL sparse_setup: chan=%0d want 1", out_chan);
        end
        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            #1;
            n_checks++;
            if (in_ready !== (M'(1) << exp_g[c])) begin
                n_fail++; $display("FAIL sparse_ready[%0d]: in_ready=%b want bit %0d", c, in_ready, exp_g[c]);
            end
            model_tick();
            n_checks++;
            if (out_chan !== SW'(exp_g[c]) || out_data !== m_data) begin
                n_fail++; $display("FAIL sparse_grant[%0d]: chan=%0d want %0d", c, out_chan, exp_g[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [M-1:0] exp;
        mode = 1'b0; sel = '0; in_valid = 4'b0001; out_ready = 1'b1;
        in_data[N-1:0] = 32'hA5;
        #1;
        model_tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = M'($urandom()); mode = 1'($urandom()); sel = SW'($urandom()); rand_data();
            #1;
            n_checks++;
            if (in_ready !== '0) begin
                n_fail++; $display("FAIL bp_ready[%0d]: in_ready=%b want 0000", c, in_ready);
            end
            model_tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hA5 || out_chan !== 2'd0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: valid=%b data=%h chan=%0d want 1/a5/0", c, out_valid, out_data, out_chan);
            end
        end
        out_ready = 1'b1; mode = 1'b1; in_valid = 4'b0110; rand_data();
        #1;
        exp = exp_ready();
        n_checks++;
        if (in_ready !== exp) begin
            n_fail++; $display("FAIL bp_release_ready: in_ready=%b want %b", in_ready, exp);
        end
        model_tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== m_data || out_chan !== SW'(m_chan)) begin
            n_fail++; $display("FAIL bp_release: valid=%b data=%h chan=%0d want 1/%h/%0d", out_valid, out_data, out_chan, m_data, m_chan);
        end
    endtask

    task automatic test_random();
        logic [M-1:0] exp;
        for (int c = 0; c < 300; c++) begin
            in_valid = M'($urandom()); mode = 1'($urandom()); sel = SW'($urandom());
            out_ready = ($urandom_range(0, 3) != 0); rand_data();
            #1;
            exp = exp_ready();
            n_checks++;
            if (in_ready !== exp) begin
                n_fail++; $display("FAIL rand_ready[%0d]: in_ready=%b want %b", c, in_ready, exp);
            end
            model_tick();
            n_checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_chan !== SW'(m_chan)) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: valid=%b data=%h chan=%0d want %b/%h/%0d", c, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
            end
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd1; in_valid3 = '1; out_ready3 = 1'b0;
        in_data3 = {8'h77, 8'h5A, 8'h33};
        #1;
        n_checks++;
        if (in_ready3 !== 3'b010) begin
            n_fail++; $display("FAIL oor_load_ready: in_ready=%b want 010", in_ready3);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== 8'h5A || out_chan3 !== 2'd1) begin
            n_fail++; $display("FAIL oor_load: valid=%b data=%h chan=%0d want 1/5a/1", out_valid3, out_data3, out_chan3);
        end
        sel3 = 2'd3; out_ready3 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (in_ready3 !== 3'b000) begin
                n_fail++; $display("FAIL oor_ready[%0d]: in_ready=%b want 000", c, in_ready3);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid3 !== 1'b0 || out_data3 !== 8'h5A || out_chan3 !== 2'd1) begin
                n_fail++; $display("FAIL oor_drain[%0d]: valid=%b data=%h chan=%0d want 0/5a/1", c, out_valid3, out_data3, out_chan3);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst3 = 1'b1; in_valid3 = '0; in_data3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
        in_data = '0;
        model_reset();
        test_reset();
        test_select();
        test_fairness();
        test_sparse();
        test_backpressure();
        do_reset();
        test_random();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised M-channel, N-bit stream multiplexer. It is the successor to the combinational 4:1 select mux.
- Each input channel has its own valid/ready handshake. A single registered output stage uses a valid/ready handshake.
- Two selection modes: external select, like the legacy Sel behaviour, or round-robin arbitration.
- Used in the hash datapath to funnel message-word sources (register file, memory, constant ROM, feedback) into the hash core input.

Parameters:
- N, 32, data width in bits (>=1).
- M, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width. Must be >= ceil(log2(M)).

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous active-high reset.
- InValid  input  M  per-channel valid; bit i belongs to channel i.
- InData  input  M*N  flattened channel data; channel i occupies bits [i*N+N-1 : i*N].
- InReady  output  M  per-channel ready. Combinational; at most one bit high.
- Mode  input  1  0 = external select, 1 = round-robin.
- Sel  input  SEL_W  channel index used when Mode=0.
- OutValid  output  1  output register holds a word.
- OutData  output  N  registered output word.
- OutChan  output  SEL_W  index of the channel OutData came from.
- OutReady  input  1  downstream accepts the word.

Behaviour:
- Reset (async, Rst=1):
  - OutValid=0, OutData=0, OutChan=0, round-robin pointer RrPtr=0.
  - InReady=0 while Rst is high.
  - A reset mid-transfer discards the held word; nothing is replayed.
- Load enable: LoadEn = !OutValid | OutReady. The output register is a 1-entry pipeline stage and sustains 1 word/cycle under continuous OutReady.
- Grant, combinational, only when LoadEn=1:
  - Mode=0: grant channel Sel if Sel<M and InValid[Sel]=1.
  - Mode=0 with Sel>=M: no grant, all InReady=0, no stall or error.
  - Mode=1: grant the first channel with InValid=1, searching from RrPtr upward and wrapping M-1 to 0.
  - No valid channel: no grant.
- InReady[g]=1 only for the granted channel g, and only when LoadEn=1. All other InReady bits are 0.
- Transfer on a rising edge with InValid[g]&InReady[g]:
  - OutData <= channel g data, OutChan <= g, OutValid <= 1.
  - Mode=1 only: RrPtr <= (g+1) mod M. RrPtr is unchanged in Mode=0 and on cycles with no transfer.
- Drain: OutValid&OutReady with no new transfer sets OutValid <= 0. OutData and OutChan keep their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and OutValid stays 1. No bubble.
- Backpressure: with OutValid=1 and OutReady=0, OutData and OutChan hold stable and all InReady=0.
- Latency: 1 cycle from input handshake to OutValid.
- Mode or Sel changes are sampled combinationally each cycle. A held output word is never altered by them.
- Fairness (Mode=1): with all M channels continuously valid and OutReady=1, grants cycle 0,1,...,M-1,0,... Each channel receives exactly one grant in every M consecutive transfers.
- No data width conversion. Each channel passes data bit-exact.

Test Plan:
- Reset: assert Rst mid-stream with OutValid=1 and OutData=0xDEADBEEF -> OutValid=0, OutData=0, OutChan=0 immediately; after release the first Mode=1 grant goes to channel 0.
- Mode=0 select: Sel=2, InValid=4'b1111, InData channels = 0x10,0x11,0x12,0x13, OutReady=1 -> InReady=4'b0100; next cycle OutData=0x12, OutChan=2; 0x12 streams every cycle.
- Mode=1 fairness: all 4 valid, OutReady=1 for 8 cycles -> OutChan sequence 0,1,2,3,0,1,2,3; each InReady bit high exactly twice.
- Mode=1 sparse: only channels 1 and 3 valid, RrPtr=2 -> grants 3,1,3,1; RrPtr values 0,2,0,2.
- Backpressure: OutValid=1 with OutData=0xA5, OutReady=0 for 5 cycles while inputs change -> OutData stays 0xA5, InReady=0; OutReady=1 then loads the next word with no bubble.
- Out-of-range select with M=3 and SEL_W=2: Mode=0, Sel=3, all inputs valid -> InReady=3'b000, OutValid falls to 0 after draining the held word.
